tia_player_graphics_scanner: RTL and testbench



---
 rtl/tia_pkg.sv | 24 ++
 rtl/tia_player_graphics_scanner_if.sv | 26 ++
 rtl/tia_player_graphics_regs.sv | 50 +++++
 rtl/tia_player_graphics_scanner.sv | 109 ++++++++++
 tb/tb_tia_player_graphics_scanner.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/tia_pkg.sv
// Shared TIA player definitions: size encodings, scanner states, graphics width.
package tia_pkg;

    localparam int TIA_GFX_WIDTH = 8;

    localparam logic [1:0] TIA_SIZE_1X = 2'b00;
    localparam logic [1:0] TIA_SIZE_2X = 2'b01;
    localparam logic [1:0] TIA_SIZE_4X = 2'b10;

    typedef enum logic {
        SCAN_IDLE = 1'b0,
        SCAN_RUN  = 1'b1
    } scan_state_e;

    // Both 2'b10 and 2'b11 stretch by 4, so anything beyond 2X maps to shift 2.
    function automatic logic [1:0] size_shift(input logic [1:0] size);
        case (size)
            TIA_SIZE_1X: size_shift = 2'd0;
            TIA_SIZE_2X: size_shift = 2'd1;
            default:     size_shift = 2'd2;
        endcase
    endfunction

endpackage

// File: rtl/tia_player_graphics_scanner_if.sv
// Control/data bundle between the position counter / register bus and the player scanner.
interface tia_player_graphics_scanner_if
    import tia_pkg::*;
#(
    parameter int GFX_WIDTH = TIA_GFX_WIDTH
);
    logic                 start_bar;
    logic [1:0]           size;
    logic                 refl;
    logic                 vdel;
    logic [GFX_WIDTH-1:0] d;
    logic                 grp_we;
    logic                 grp_copy;
    logic                 pgfx;
    logic                 scan_active;

    modport master (
        output start_bar, size, refl, vdel, d, grp_we, grp_copy,
        input  pgfx, scan_active
    );

    modport slave (
        input  start_bar, size, refl, vdel, d, grp_we, grp_copy,
        output pgfx, scan_active
    );
endinterface

// File: rtl/tia_player_graphics_regs.sv
// Player graphics registers: new register, optional vertical-delay old register and source select.
// The old register exists only when TIA_PLAYER_VDEL_EN is defined.
module tia_player_graphics_regs
    import tia_pkg::*;
#(
    parameter int GFX_WIDTH = TIA_GFX_WIDTH
) (
    input  logic                 motck,
    input  logic                 reset_bar,
    input  logic [GFX_WIDTH-1:0] d,
    input  logic                 grp_we,
    input  logic                 grp_copy,
    input  logic                 vdel,
    output logic [GFX_WIDTH-1:0] src
);

    logic [GFX_WIDTH-1:0] grp_new_q, grp_new_d;

    always_comb begin
        grp_new_d = grp_new_q;
        if (grp_we) grp_new_d = d;
    end

    always_ff @(posedge motck or negedge reset_bar) begin
        if (!reset_bar) grp_new_q <= '0;
        else            grp_new_q <= grp_new_d;
    end

`ifdef TIA_PLAYER_VDEL_EN
    logic [GFX_WIDTH-1:0] grp_old_q, grp_old_d;

    // Copy takes the pre-edge new value, so a simultaneous write still moves the old contents.
    always_comb begin
        grp_old_d = grp_old_q;
        if (grp_copy) grp_old_d = grp_new_q;
    end

    always_ff @(posedge motck or negedge reset_bar) begin
        if (!reset_bar) grp_old_q <= '0;
        else            grp_old_q <= grp_old_d;
    end

    assign src = vdel ? grp_old_q : grp_new_q;
`else
    logic unused_vdel_inputs;
    assign unused_vdel_inputs = vdel ^ grp_copy;
    assign src = grp_new_q;
`endif

endmodule

// File: rtl/tia_player_graphics_scanner.sv
// TIA player graphics scanner: serializes the selected graphics register into one pixel per colour clock.
// Vertical-delay register is built only with TIA_PLAYER_VDEL_EN defined.
module tia_player_graphics_scanner
    import tia_pkg::*;
#(
    parameter int GFX_WIDTH = TIA_GFX_WIDTH
) (
    input  logic                          motck,
    input  logic                          reset_bar,
    tia_player_graphics_scanner_if.slave  bus
);

    localparam int IDX_W = $clog2(GFX_WIDTH);
    localparam int CNT_W = IDX_W + 2;

    logic [GFX_WIDTH-1:0] src;

    scan_state_e          state_q, state_d;
    logic [CNT_W-1:0]     pix_cnt_q, pix_cnt_d;
    logic [1:0]           shift_q, shift_d;
    logic                 start_q, start_d;
    logic                 pgfx_q, pgfx_d;
    logic                 scan_active_q, scan_active_d;
    logic                 start_det;
    logic [1:0]           live_shift;
    logic [CNT_W-1:0]     next_cnt;

    tia_player_graphics_regs #(
        .GFX_WIDTH (GFX_WIDTH)
    ) u_regs (
        .motck     (motck),
        .reset_bar (reset_bar),
        .d         (bus.d),
        .grp_we    (bus.grp_we),
        .grp_copy  (bus.grp_copy),
        .vdel      (bus.vdel),
        .src       (src)
    );

    // Pixel index wraps to the register width if size shrinks mid-scan.
    function automatic logic pick_bit(input logic [GFX_WIDTH-1:0] gfx,
                                      input logic [CNT_W-1:0]     cnt,
                                      input logic [1:0]           shift,
                                      input logic                 reflect);
        logic [CNT_W-1:0] full;
        logic [IDX_W-1:0] idx;
        logic [IDX_W-1:0] ridx;
        full = cnt >> shift;
        idx  = full[IDX_W-1:0];
        ridx = IDX_W'(GFX_WIDTH - 1) - idx;
        return reflect ? gfx[idx] : gfx[ridx];
    endfunction

    function automatic logic [CNT_W-1:0] last_cnt(input logic [1:0] shift);
        return CNT_W'((GFX_WIDTH << shift) - 1);
    endfunction

    assign start_det  = bus.start_bar & ~start_q;
    assign live_shift = size_shift(bus.size);
    assign next_cnt   = pix_cnt_q + CNT_W'(1);

    // Restart takes priority over end-of-scan; pgfx holds the pixel indexed by pix_cnt.
    always_comb begin
        state_d       = state_q;
        pix_cnt_d     = pix_cnt_q;
        shift_d       = shift_q;
        start_d       = bus.start_bar;
        pgfx_d        = 1'b0;
        scan_active_d = 1'b0;

        if (start_det) begin
            state_d       = SCAN_RUN;
            pix_cnt_d     = '0;
            shift_d       = live_shift;
            pgfx_d        = pick_bit(src, '0, live_shift, bus.refl);
            scan_active_d = 1'b1;
        end else if (state_q == SCAN_RUN) begin
            if (pix_cnt_q == last_cnt(shift_q)) begin
                state_d = SCAN_IDLE;
            end else begin
                pix_cnt_d     = next_cnt;
                pgfx_d        = pick_bit(src, next_cnt, live_shift, bus.refl);
                scan_active_d = 1'b1;
            end
        end
    end

    always_ff @(posedge motck or negedge reset_bar) begin
        if (!reset_bar) begin
            state_q       <= SCAN_IDLE;
            pix_cnt_q     <= '0;
            shift_q       <= '0;
            start_q       <= 1'b1;
            pgfx_q        <= 1'b0;
            scan_active_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pix_cnt_q     <= pix_cnt_d;
            shift_q       <= shift_d;
            start_q       <= start_d;
            pgfx_q        <= pgfx_d;
            scan_active_q <= scan_active_d;
        end
    end

    assign bus.pgfx        = pgfx_q;
    assign bus.scan_active = scan_active_q;

endmodule

// File: tb/tb_tia_player_graphics_scanner.sv
// Self-checking bench for tia_player_graphics_scanner: per-cycle model comparison plus literal pattern checks.
module tb_tia_player_graphics_scanner;

    logic motck = 1'b0;
    logic reset_bar;

    always #5 motck = ~motck;

    tia_player_graphics_scanner_if #(.GFX_WIDTH(8)) bus ();

    tia_player_graphics_scanner #(.GFX_WIDTH(8)) dut (
        .motck     (motck),
        .reset_bar (reset_bar),
        .bus       (bus)
    );

`ifdef TIA_PLAYER_VDEL_EN
    localparam bit VDEL_EN = 1'b1;
`else
    localparam bit VDEL_EN = 1'b0;
`endif

    int errors = 0;
    int checks = 0;

    // Model state: registers, previous start_bar, and scan progress as plain integers.
    logic [7:0] m_new, m_old;
    logic       m_prev_start;
    bit         m_active;
    int         m_k, m_s, m_n;
    logic       m_pgfx, m_act;

    logic trace_p [0:127];
    logic trace_a [0:127];
    int   cc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cc=%0d t=%0t)", name, act, exp, cc, $time);
        end
    endtask

    task automatic model_reset();
        m_new = 8'h00; m_old = 8'h00; m_prev_start = 1'b1;
        m_active = 1'b0; m_k = 0; m_s = 0; m_n = 8;
        m_pgfx = 1'b0; m_act = 1'b0;
    endtask

    function automatic int shift_of(input logic [1:0] sz);
        if (sz == 2'b00) return 0;
        if (sz == 2'b01) return 1;
        return 2;
    endfunction

    // Advance the model by one edge using the inputs presented to that edge.
    task automatic model_edge();
        logic [7:0] srcv;
        int         idx;
        bit         det;
        if (!reset_bar) return;
        det  = bus.start_bar && !m_prev_start;
        srcv = (VDEL_EN && bus.vdel) ? m_old : m_new;
        if (det) begin
            m_active = 1'b1; m_k = 0; m_s = shift_of(bus.size); m_n = 8 << m_s;
        end else if (m_active) begin
            m_k++;
            if (m_k == m_n) m_active = 1'b0;
        end
        if (m_active) begin
            idx    = (m_k >> shift_of(bus.size)) % 8;
            m_pgfx = bus.refl ? srcv[idx] : srcv[7 - idx];
        end else begin
            m_pgfx = 1'b0;
        end
        m_act = m_active;
        if (VDEL_EN && bus.grp_copy) m_old = m_new;
        if (bus.grp_we) m_new = bus.d;
        m_prev_start = bus.start_bar;
    endtask

    task automatic step();
        model_edge();
        @(posedge motck);
        #1;
        if (cc >= 0 && cc < 128) begin
            trace_p[cc] = bus.pgfx;
            trace_a[cc] = bus.scan_active;
        end
        check("pgfx", {31'd0, bus.pgfx}, {31'd0, m_pgfx});
        check("scan_active", {31'd0, bus.scan_active}, {31'd0, m_act});
        cc++;
    endtask

    task automatic idle(input int n);
        bus.start_bar = 1'b1; bus.grp_we = 1'b0; bus.grp_copy = 1'b0;
        repeat (n) step();
    endtask

    task automatic write_new(input logic [7:0] v);
        bus.grp_we = 1'b1; bus.d = v;
        step();
        bus.grp_we = 1'b0;
    endtask

    // 4 low cycles from cc0, then high for the rest of the window.
    task automatic scan_window(input int len);
        cc = 0;
        for (int i = 0; i < len; i++) begin
            bus.start_bar = (i < 4) ? 1'b0 : 1'b1;
            step();
        end
    endtask

    task automatic check_pattern(input string name, input logic [7:0] pat);
        logic [7:0] p;
        p = pat;
        for (int i = 0; i < 8; i++) check(name, {31'd0, trace_p[4 + i]}, {31'd0, p[7 - i]});
        check({name, "_end"}, {31'd0, trace_p[12]}, 32'd0);
    endtask

    initial begin
        logic [7:0] exp_byte;
        int         ones;

        reset_bar = 1'b0;
        bus.start_bar = 1'b1; bus.size = 2'b00; bus.refl = 1'b0; bus.vdel = 1'b0;
        bus.d = 8'h00; bus.grp_we = 1'b0; bus.grp_copy = 1'b0;
        model_reset();
        cc = 0;
        #3;
        check("rst_pgfx", {31'd0, bus.pgfx}, 32'd0);
        check("rst_scan_active", {31'd0, bus.scan_active}, 32'd0);
        step(); step();
        reset_bar = 1'b1;
        idle(3);

        // 1x normal scan of A5
        write_new(8'hA5);
        idle(2);
        scan_window(16);
        check_pattern("t1_pix", 8'hA5);
        check("t1_act_pre", {31'd0, trace_a[3]}, 32'd0);
        for (int i = 4; i < 12; i++) check("t1_act", {31'd0, trace_a[i]}, 32'd1);
        check("t1_act_post", {31'd0, trace_a[12]}, 32'd0);

        // 2x reflected scan of 81
        write_new(8'h81);
        bus.refl = 1'b1; bus.size = 2'b01;
        idle(2);
        scan_window(24);
        for (int i = 0; i < 24; i++)
            check("t2_pix", {31'd0, trace_p[i]},
                  (i == 4 || i == 5 || i == 18 || i == 19) ? 32'd1 : 32'd0);
        check("t2_act_last", {31'd0, trace_a[19]}, 32'd1);
        check("t2_act_end", {31'd0, trace_a[20]}, 32'd0);

        // vertical delay, 4x
        bus.refl = 1'b0;
        write_new(8'hFF);
        bus.grp_copy = 1'b1; step(); bus.grp_copy = 1'b0;
        write_new(8'h00);
        bus.vdel = 1'b1; bus.size = 2'b10;
        idle(2);
        scan_window(40);
        ones = 0;
        for (int i = 4; i < 36; i++) ones += int'(trace_p[i]);
        check("t3_ones", ones, VDEL_EN ? 32'd32 : 32'd0);
        check("t3_act_last", {31'd0, trace_a[35]}, 32'd1);
        check("t3_act_end", {31'd0, trace_a[36]}, 32'd0);
        bus.vdel = 1'b0;

        // close copies, 1x F0
        write_new(8'hF0);
        bus.size = 2'b00;
        idle(2);
        cc = 0;
        for (int i = 0; i < 32; i++) begin
            bus.start_bar = (i < 4 || (i >= 16 && i < 20)) ? 1'b0 : 1'b1;
            step();
        end
        for (int i = 0; i < 32; i++)
            check("t4_pix", {31'd0, trace_p[i]},
                  ((i >= 4 && i <= 7) || (i >= 20 && i <= 23)) ? 32'd1 : 32'd0);

        // 4x restart: second start detected at cc20 keeps scan_active through cc51
        write_new(8'hC3);
        bus.size = 2'b10;
        idle(2);
        cc = 0;
        for (int i = 0; i < 56; i++) begin
            bus.start_bar = (i < 4 || (i >= 16 && i < 20)) ? 1'b0 : 1'b1;
            step();
        end
        for (int i = 0; i < 56; i++)
            check("t5_act", {31'd0, trace_a[i]}, (i >= 4 && i <= 51) ? 32'd1 : 32'd0);
        check("t5_pix20", {31'd0, trace_p[20]}, 32'd1);
        check("t5_pix28", {31'd0, trace_p[28]}, 32'd0);

        // async reset mid-scan at cc30
        idle(2);
        scan_window(30);
        #2;
        reset_bar = 1'b0;
        #1;
        model_reset();
        check("t5_rst_pgfx", {31'd0, bus.pgfx}, 32'd0);
        check("t5_rst_act", {31'd0, bus.scan_active}, 32'd0);
        step(); step();
        reset_bar = 1'b1;
        idle(10);
        bus.size = 2'b00;
        scan_window(14);
        ones = 0;
        for (int i = 4; i < 12; i++) ones += int'(trace_p[i]);
        check("t5_grp_new_cleared", ones, 32'd0);
        check("t5_post_rst_act", {31'd0, trace_a[4]}, 32'd1);

        // simultaneous write and copy
        write_new(8'h3C);
        bus.grp_we = 1'b1; bus.d = 8'h55; bus.grp_copy = 1'b1;
        step();
        bus.grp_we = 1'b0; bus.grp_copy = 1'b0;
        idle(2);
        scan_window(14);
        check_pattern("t6_new", 8'h55);
        bus.vdel = 1'b1;
        idle(2);
        scan_window(14);
        exp_byte = VDEL_EN ? 8'h3C : 8'h55;
        check_pattern("t6_old", exp_byte);
        bus.vdel = 1'b0;
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
